punc_datapath_mc: RTL and testbench

- Parametrised next-generation PUnC datapath: DATA_W-wide ALU, NREGS-entry register file, registered PC/IR/MDR and NZP flags.
- Memory moves off-block behind a valid/ready request/response port driven by an internal access sequencer, so memory latency is arbitrary.
- Sits between the PUnC controller FSM and the external memory system.
- All state updates are registered on clk.

---
 rtl/punc_pkg.sv | 48 ++++
 rtl/punc_mem_access.sv | 120 ++++++++++++
 rtl/punc_datapath_mc.sv | 205 ++++++++++++++++++++
 tb/tb_punc_datapath_mc.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/punc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : punc_pkg
// Description : Shared encodings for the PUnC multi-cycle datapath: ALU ops,
//               PC ops, register write-data selects, access address selects
//               and the memory-access sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package punc_pkg;

    // ALU operation encodings
    localparam logic [2:0] c_alu_add   = 3'd0;
    localparam logic [2:0] c_alu_and   = 3'd1;
    localparam logic [2:0] c_alu_not   = 3'd2;
    localparam logic [2:0] c_alu_passa = 3'd3;
    localparam logic [2:0] c_alu_xor   = 3'd4;
    localparam logic [2:0] c_alu_shl1  = 3'd5;
    localparam logic [2:0] c_alu_shr1  = 3'd6;
    localparam logic [2:0] c_alu_passb = 3'd7;

    // PC update encodings
    localparam logic [1:0] c_pc_hold = 2'd0;
    localparam logic [1:0] c_pc_inc  = 2'd1;
    localparam logic [1:0] c_pc_load = 2'd2;
    localparam logic [1:0] c_pc_add  = 2'd3;

    // Register-file write-data select
    localparam logic [1:0] c_wd_alu   = 2'd0;
    localparam logic [1:0] c_wd_mdr   = 2'd1;
    localparam logic [1:0] c_wd_pc    = 2'd2;
    localparam logic [1:0] c_wd_pcoff = 2'd3;

    // Memory access address select
    localparam logic [1:0] c_asel_pc    = 2'd0;
    localparam logic [1:0] c_asel_pcoff = 2'd1;
    localparam logic [1:0] c_asel_rfoff = 2'd2;
    localparam logic [1:0] c_asel_mdr   = 2'd3;

    // Memory access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/punc_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : punc_mem_access
// Description : Memory access sequencer for the PUnC datapath. Captures the
//               access address, direction and write data on acc_start, runs
//               the valid/ready request and waits for the read response,
//               which is stored in MDR.
// Revision    : 1.0 - initial release
// ============================================================================
module punc_mem_access #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_start,
    input  logic              acc_we,
    input  logic [1:0]        acc_asel,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] rf_rdata0,
    input  logic [DATA_W-1:0] alu_result,
    output logic              acc_busy,
    output logic              acc_done,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic [DATA_W-1:0] mdr
);
    import punc_pkg::*;

    acc_state_t        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_req_valid;
    logic [DATA_W-1:0] r_req_addr;
    logic              r_req_we;
    logic [DATA_W-1:0] r_req_wdata;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] w_acc_addr;

    // Access address selection, evaluated in the cycle acc_start is seen
    always_comb begin
        w_acc_addr = pc;
        case (acc_asel)
            c_asel_pc:    w_acc_addr = pc;
            c_asel_pcoff: w_acc_addr = pc + offset;
            c_asel_rfoff: w_acc_addr = rf_rdata0 + offset;
            c_asel_mdr:   w_acc_addr = r_mdr;
            default:      w_acc_addr = pc;
        endcase
    end

    // Access sequencer; status and request outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_we    <= 1'b0;
            r_req_wdata <= '0;
            r_mdr       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (acc_start) begin
                        r_req_addr  <= w_acc_addr;
                        r_req_we    <= acc_we;
                        r_req_wdata <= alu_result;
                        r_req_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        if (r_req_we) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    if (mem_rsp_valid) begin
                        r_mdr   <= mem_rsp_data;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign acc_busy      = r_busy;
    assign acc_done      = r_done;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_we    = r_req_we;
    assign mem_req_wdata = r_req_wdata;
    assign mdr           = r_mdr;

endmodule
`default_nettype wire

// File: rtl/punc_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module      : punc_datapath_mc
// Description : Parametrised PUnC multi-cycle datapath: ALU, register file,
//               PC, IR and NZP flags, with memory reached through a
//               valid/ready access sequencer (punc_mem_access).
//               Build option PUNC_OVF_FLAG_EN adds the signed-overflow flag v.
// Revision    : 1.0 - initial release
// ============================================================================
module punc_datapath_mc #(
    parameter  int DATA_W = 16,
    parameter  int NREGS  = 8,
    localparam int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_op,
    input  logic              pc_clr,
    input  logic              ir_ld,
    input  logic [RA_W-1:0]   rf_raddr0,
    input  logic [RA_W-1:0]   rf_raddr1,
    input  logic [RA_W-1:0]   rf_waddr,
    input  logic              rf_we,
    input  logic [1:0]        wd_sel,
    input  logic [2:0]        alu_op,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] offset,
    input  logic              cc_ld,
    input  logic              acc_start,
    input  logic              acc_we,
    input  logic [1:0]        acc_asel,
    output logic              acc_busy,
    output logic              acc_done,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic [DATA_W-1:0] ir,
    output logic              n,
    output logic              z,
    output logic              p,
    input  logic [RA_W-1:0]   rf_debug_addr,
    output logic [DATA_W-1:0] rf_debug_data,
`ifdef PUNC_OVF_FLAG_EN
    output logic              v,
`endif
    output logic [DATA_W-1:0] pc_debug_data
);
    import punc_pkg::*;

    logic [DATA_W-1:0] r_rf [NREGS];
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic              r_n;
    logic              r_z;
    logic              r_p;
    logic [DATA_W-1:0] w_rdata0;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu_result;
    logic [DATA_W-1:0] w_pc_off;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_mdr;

    assign w_rdata0 = r_rf[rf_raddr0];
    assign w_rdata1 = r_rf[rf_raddr1];
    assign w_alu_b  = imm_sel ? imm : w_rdata1;
    assign w_pc_off = r_pc + offset;

    // ALU: combinational, all results wrap modulo 2^DATA_W
    always_comb begin
        w_alu_result = '0;
        case (alu_op)
            c_alu_add:   w_alu_result = w_rdata0 + w_alu_b;
            c_alu_and:   w_alu_result = w_rdata0 & w_alu_b;
            c_alu_not:   w_alu_result = ~w_rdata0;
            c_alu_passa: w_alu_result = w_rdata0;
            c_alu_xor:   w_alu_result = w_rdata0 ^ w_alu_b;
            c_alu_shl1:  w_alu_result = {w_rdata0[DATA_W-2:0], 1'b0};
            c_alu_shr1:  w_alu_result = {w_rdata0[DATA_W-1], w_rdata0[DATA_W-1:1]};
            c_alu_passb: w_alu_result = w_alu_b;
            default:     w_alu_result = '0;
        endcase
    end

    // Register-file write-data selection
    always_comb begin
        w_wdata = w_alu_result;
        case (wd_sel)
            c_wd_alu:   w_wdata = w_alu_result;
            c_wd_mdr:   w_wdata = w_mdr;
            c_wd_pc:    w_wdata = r_pc;
            c_wd_pcoff: w_wdata = w_pc_off;
            default:    w_wdata = w_alu_result;
        endcase
    end

    // Register file: reads above are of the pre-edge contents, so write-then-read returns old data
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (rf_we) begin
            r_rf[rf_waddr] <= w_wdata;
        end
    end

    // PC update; clear takes priority over any pc_op
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= '0;
        end else if (pc_clr) begin
            r_pc <= '0;
        end else begin
            case (pc_op)
                c_pc_hold: r_pc <= r_pc;
                c_pc_inc:  r_pc <= r_pc + DATA_W'(1);
                c_pc_load: r_pc <= w_rdata0;
                c_pc_add:  r_pc <= w_pc_off;
                default:   r_pc <= r_pc;
            endcase
        end
    end

    // IR load takes the MDR value present before this edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ir <= '0;
        end else if (ir_ld) begin
            r_ir <= w_mdr;
        end
    end

    // NZP flags: exactly one is set after reset or any cc_ld update
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_n <= 1'b0;
            r_z <= 1'b1;
            r_p <= 1'b0;
        end else if (cc_ld) begin
            r_n <= w_alu_result[DATA_W-1];
            r_z <= (w_alu_result == '0);
            r_p <= !w_alu_result[DATA_W-1] && (w_alu_result != '0);
        end
    end

`ifdef PUNC_OVF_FLAG_EN
    logic r_v;
    logic w_add_ovf;

    // Signed overflow of ADD: equal-sign operands producing a result of the other sign
    assign w_add_ovf = (alu_op == c_alu_add)
                    && (w_rdata0[DATA_W-1] == w_alu_b[DATA_W-1])
                    && (w_alu_result[DATA_W-1] != w_rdata0[DATA_W-1]);

    // Overflow flag updated together with NZP
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v <= 1'b0;
        end else if (cc_ld) begin
            r_v <= w_add_ovf;
        end
    end

    assign v = r_v;
`endif

    punc_mem_access #(
        .DATA_W (DATA_W)
    ) u_mem_access (
        .clk           (clk),
        .rst           (rst),
        .acc_start     (acc_start),
        .acc_we        (acc_we),
        .acc_asel      (acc_asel),
        .pc            (r_pc),
        .offset        (offset),
        .rf_rdata0     (w_rdata0),
        .alu_result    (w_alu_result),
        .acc_busy      (acc_busy),
        .acc_done      (acc_done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mdr           (w_mdr)
    );

    assign ir            = r_ir;
    assign n             = r_n;
    assign z             = r_z;
    assign p             = r_p;
    assign rf_debug_data = r_rf[rf_debug_addr];
    assign pc_debug_data = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_punc_datapath_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_punc_datapath_mc
// Description : Self-checking bench for punc_datapath_mc. Directed scenarios
//               followed by randomized operations against a behavioural model;
//               memory requests are checked by a scoreboard monitor.
//               Define PUNC_OVF_FLAG_EN to also exercise the v flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_punc_datapath_mc;
    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int RA_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        pc_op;
    logic              pc_clr, ir_ld, rf_we, imm_sel, cc_ld;
    logic [RA_W-1:0]   rf_raddr0, rf_raddr1, rf_waddr, rf_debug_addr;
    logic [1:0]        wd_sel, acc_asel;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] imm, offset;
    logic              acc_start, acc_we, acc_busy, acc_done;
    logic              mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
    logic [DATA_W-1:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [DATA_W-1:0] ir, rf_debug_data, pc_debug_data;
    logic              n, z, p;
`ifdef PUNC_OVF_FLAG_EN
    logic              v;
`endif

    always #5 clk = ~clk;

    punc_datapath_mc #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .pc_op(pc_op), .pc_clr(pc_clr), .ir_ld(ir_ld),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .wd_sel(wd_sel), .alu_op(alu_op), .imm_sel(imm_sel),
        .imm(imm), .offset(offset), .cc_ld(cc_ld), .acc_start(acc_start),
        .acc_we(acc_we), .acc_asel(acc_asel), .acc_busy(acc_busy),
        .acc_done(acc_done), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .ir(ir),
        .n(n), .z(z), .p(p), .rf_debug_addr(rf_debug_addr),
        .rf_debug_data(rf_debug_data),
`ifdef PUNC_OVF_FLAG_EN
        .v(v),
`endif
        .pc_debug_data(pc_debug_data)
    );

    typedef struct packed {
        logic [1:0]  pc_op;
        logic        pc_clr;
        logic        ir_ld;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic [2:0]  wa;
        logic        we;
        logic [1:0]  wd_sel;
        logic [2:0]  alu_op;
        logic        imm_sel;
        logic [15:0] imm;
        logic [15:0] offset;
        logic        cc_ld;
    } ctrl_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } req_t;

    // Behavioural model state
    logic [15:0] m_rf [NREGS];
    logic [15:0] m_pc, m_ir, m_mdr;
    logic        m_n, m_z, m_p, m_v;
    req_t        req_q[$];
    int          done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a & b;
            3'd2:    return ~a;
            3'd3:    return a;
            3'd4:    return a ^ b;
            3'd5:    return a * 16'd2;
            3'd6:    return 16'($signed(a) >>> 1);
            default: return b;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return (op == 3'd0) && (s > 32767 || s < -32768);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
        m_pc = '0; m_ir = '0; m_mdr = '0;
        m_n = 1'b0; m_z = 1'b1; m_p = 1'b0; m_v = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_ctrl(input ctrl_t c);
        pc_op = c.pc_op; pc_clr = c.pc_clr; ir_ld = c.ir_ld;
        rf_raddr0 = c.ra0; rf_raddr1 = c.ra1; rf_waddr = c.wa; rf_we = c.we;
        wd_sel = c.wd_sel; alu_op = c.alu_op; imm_sel = c.imm_sel;
        imm = c.imm; offset = c.offset; cc_ld = c.cc_ld;
    endtask

    task automatic set_idle();
        apply_ctrl('0);
        acc_start = 1'b0; acc_we = 1'b0; acc_asel = 2'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    endtask

    task automatic check_state(input string tag);
        logic [2:0] da;
        da = 3'($urandom_range(0, NREGS - 1));
        check({tag, "_pc"}, 32'(pc_debug_data), 32'(m_pc));
        check({tag, "_ir"}, 32'(ir), 32'(m_ir));
        check({tag, "_nzp"}, 32'({n, z, p}), 32'({m_n, m_z, m_p}));
`ifdef PUNC_OVF_FLAG_EN
        check({tag, "_v"}, 32'(v), 32'(m_v));
`endif
        rf_debug_addr = da;
        #1;
        check({tag, "_rf"}, 32'(rf_debug_data), 32'(m_rf[da]));
    endtask

    // One datapath cycle with model update
    task automatic run_op(input ctrl_t c);
        logic [15:0] a, b, res, wd, npc;
        a   = m_rf[c.ra0];
        b   = c.imm_sel ? c.imm : m_rf[c.ra1];
        res = ref_alu(c.alu_op, a, b);
        case (c.wd_sel)
            2'd0:    wd = res;
            2'd1:    wd = m_mdr;
            2'd2:    wd = m_pc;
            default: wd = m_pc + c.offset;
        endcase
        if (c.pc_clr) npc = '0;
        else case (c.pc_op)
            2'd0:    npc = m_pc;
            2'd1:    npc = m_pc + 16'd1;
            2'd2:    npc = a;
            default: npc = m_pc + c.offset;
        endcase
        apply_ctrl(c);
        tick();
        if (c.we) m_rf[c.wa] = wd;
        if (c.ir_ld) m_ir = m_mdr;
        m_pc = npc;
        if (c.cc_ld) begin
            m_n = res[15];
            m_z = (res == 16'd0);
            m_p = !m_n && !m_z;
            m_v = ref_ovf(c.alu_op, a, b);
        end
        set_idle();
        check_state("op");
    endtask

    // mode 0: normal, 1: extra acc_start pulse while in REQ, 2: reset while in RSP
    task automatic mem_access(input logic we, input logic [1:0] asel, input ctrl_t c,
                              input int rdy_dly, input int rsp_dly,
                              input logic [15:0] rdata, input int mode);
        logic [15:0] a, b;
        req_t r;
        c.we = 1'b0; c.pc_op = 2'd0; c.pc_clr = 1'b0; c.cc_ld = 1'b0; c.ir_ld = 1'b0;
        a = m_rf[c.ra0];
        b = c.imm_sel ? c.imm : m_rf[c.ra1];
        case (asel)
            2'd0:    r.addr = m_pc;
            2'd1:    r.addr = m_pc + c.offset;
            2'd2:    r.addr = a + c.offset;
            default: r.addr = m_mdr;
        endcase
        r.we = we;
        r.wdata = ref_alu(c.alu_op, a, b);
        req_q.push_back(r);
        done_q.push_back(1);
        apply_ctrl(c);
        acc_start = 1'b1; acc_we = we; acc_asel = asel;
        tick();
        set_idle();
        check("busy_start", 32'(acc_busy), 32'd1);
        for (int i = 0; i < rdy_dly; i++) begin
            if (i == 0 && mode == 1) begin
                acc_start = 1'b1; acc_we = ~we; acc_asel = asel + 2'd1;
                offset = 16'h0040;
            end
            tick();
            acc_start = 1'b0; offset = '0;
            check("busy_req", 32'(acc_busy), 32'd1);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        if (we) begin
            check("wr_done", 32'(acc_done), 32'd1);
            tick();
            check("wr_done_pulse", 32'(acc_done), 32'd0);
            check("wr_idle_busy", 32'(acc_busy), 32'd0);
            return;
        end
        check("busy_rsp", 32'(acc_busy), 32'd1);
        if (mode == 2) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
            model_reset();
            req_q.delete();
            done_q.delete();
            mem_rsp_valid = 1'b1; mem_rsp_data = rdata;
            tick();
            mem_rsp_valid = 1'b0;
            check("rst_rsp_done", 32'(acc_done), 32'd0);
            check("rst_rsp_busy", 32'(acc_busy), 32'd0);
            check("rst_rsp_valid", 32'(mem_req_valid), 32'd0);
            tick();
            check("rst_rsp_done2", 32'(acc_done), 32'd0);
            return;
        end
        for (int i = 0; i < rsp_dly; i++) begin
            tick();
            check("busy_wait", 32'(acc_busy), 32'd1);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = rdata;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        m_mdr = rdata;
        check("rd_done", 32'(acc_done), 32'd1);
        check("rd_idle_busy", 32'(acc_busy), 32'd0);
        tick();
        check("rd_done_pulse", 32'(acc_done), 32'd0);
    endtask

    function automatic ctrl_t rand_ctrl();
        ctrl_t c;
        c = ctrl_t'({$urandom, $urandom});
        c.pc_clr = ($urandom_range(0, 19) == 0);
        return c;
    endfunction

    // Scoreboard monitor: request contents must match the expected head while
    // valid is up; the head retires on handshake; every acc_done must be expected
    always @(negedge clk) begin
        if (rst) begin
            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    check("req_spurious", 32'(mem_req_valid), 32'd0);
                end else begin
                    check("req_addr", 32'(mem_req_addr), 32'(req_q[0].addr));
                    check("req_we", 32'(mem_req_we), 32'(req_q[0].we));
                    check("req_wdata", 32'(mem_req_wdata), 32'(req_q[0].wdata));
                    if (mem_req_ready) void'(req_q.pop_front());
                end
            end
            if (acc_done) begin
                if (done_q.size() == 0) begin
                    check("done_spurious", 32'(acc_done), 32'd0);
                end else begin
                    void'(done_q.pop_front());
                    check("done_busy", 32'(acc_busy), 32'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_t c;
        rf_debug_addr = '0;
        set_idle();
        rst = 1'b0;
        model_reset();
        tick(); tick();
        check("rst_valid", 32'(mem_req_valid), 32'd0);
        check("rst_busy", 32'(acc_busy), 32'd0);
        check("rst_done", 32'(acc_done), 32'd0);
        check("rst_addr", 32'(mem_req_addr), 32'd0);
        rst = 1'b1;
        check_state("rst");

        // R1 <= 5 ; R2 = R1 + 0xFFFB with cc_ld
        c = '0; c.alu_op = 3'd7; c.imm_sel = 1'b1; c.imm = 16'h0005; c.wa = 3'd1; c.we = 1'b1;
        run_op(c);
        c = '0; c.alu_op = 3'd0; c.ra0 = 3'd1; c.imm_sel = 1'b1; c.imm = 16'hFFFB;
        c.wa = 3'd2; c.we = 1'b1; c.cc_ld = 1'b1;
        run_op(c);
        rf_debug_addr = 3'd2; #1;
        check("t1_r2", 32'(rf_debug_data), 32'h0);
        check("t1_nzp", 32'({n, z, p}), 32'b010);

        // PC <= 0x0010 through R3, then delayed read
        c = '0; c.alu_op = 3'd7; c.imm_sel = 1'b1; c.imm = 16'h0010; c.wa = 3'd3; c.we = 1'b1;
        run_op(c);
        c = '0; c.pc_op = 2'd2; c.ra0 = 3'd3;
        run_op(c);
        check("t2_pc", 32'(pc_debug_data), 32'h0010);
        mem_access(1'b0, 2'd0, '0, 3, 2, 16'h1234, 0);
        c = '0; c.ir_ld = 1'b1;
        run_op(c);
        check("t2_ir", 32'(ir), 32'h1234);

        // Write at R3 + 0xFFFF with ALU = 0xBEEF, immediate ready
        c = '0; c.alu_op = 3'd7; c.imm_sel = 1'b1; c.imm = 16'h0100; c.wa = 3'd3; c.we = 1'b1;
        run_op(c);
        c = '0; c.ra0 = 3'd3; c.offset = 16'hFFFF; c.alu_op = 3'd7; c.imm_sel = 1'b1; c.imm = 16'hBEEF;
        mem_access(1'b1, 2'd2, c, 0, 0, 16'h0, 0);

        // Extra acc_start while in REQ must be ignored
        mem_access(1'b1, 2'd1, rand_ctrl(), 2, 0, 16'h0, 1);
        mem_access(1'b0, 2'd0, rand_ctrl(), 2, 1, 16'hA5A5, 1);

        // Reset while waiting for the read response
        mem_access(1'b0, 2'd0, '0, 0, 0, 16'h5555, 2);
        c = '0; c.ir_ld = 1'b1;
        run_op(c);
        check("rst_rsp_mdr", 32'(ir), 32'h0);

`ifdef PUNC_OVF_FLAG_EN
        c = '0; c.alu_op = 3'd7; c.imm_sel = 1'b1; c.imm = 16'h7FFF; c.wa = 3'd1; c.we = 1'b1;
        run_op(c);
        c = '0; c.alu_op = 3'd0; c.ra0 = 3'd1; c.imm_sel = 1'b1; c.imm = 16'h0001; c.cc_ld = 1'b1;
        c.wa = 3'd4; c.we = 1'b1;
        run_op(c);
        check("ovf_v", 32'(v), 32'd1);
        check("ovf_n", 32'(n), 32'd1);
        c.alu_op = 3'd1; c.we = 1'b0;
        run_op(c);
        check("ovf_and_v", 32'(v), 32'd0);
`endif

        // Randomized mix of datapath operations and memory accesses
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                mem_access(1'($urandom), 2'($urandom), rand_ctrl(),
                           $urandom_range(0, 3), $urandom_range(0, 3),
                           16'($urandom), ($urandom_range(0, 5) == 0) ? 1 : 0);
                check_state("acc");
            end else begin
                run_op(rand_ctrl());
            end
        end

        tick(); tick();
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
